// File: rtl/approx_pkg.sv
// Shared constants and types for the approximate-adder error monitor.
package approx_pkg;
  localparam int ADD_W     = 40;
  localparam int CNT_W     = 16;
  localparam int ERR_W_DEF = 56;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } mon_state_t;
endpackage

// File: rtl/approx_abs_diff.sv
// Combinational unsigned absolute difference |x - y|.
module approx_abs_diff
  import approx_pkg::*;
(
  input  logic [ADD_W-1:0] x,
  input  logic [ADD_W-1:0] y,
  output logic [ADD_W-1:0] mag
);
  assign mag = (x >= y) ? (x - y) : (y - x);
endmodule

// File: rtl/approx_error_monitor.sv
// Windowed error statistics for an approximate adder: mismatch count,
// saturating error sum and (with APPROX_ERR_MAX_EN) maximum error.
module approx_error_monitor
  import approx_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  input  logic [ADD_W-1:0] Approx,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [ERR_W-1:0] err_sum,
  output logic [ADD_W-1:0] err_max
);
  localparam int SW = ((ERR_W > ADD_W) ? ERR_W : ADD_W) + 1;

  mon_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             drain_reg, drain_next;

  logic             v0_reg, v1_reg, mis1_reg;
  logic [ADD_W-1:0] exact0_reg, approx0_reg, err1_reg, diff;
  logic [CNT_W-1:0] mism_reg;
  logic [ERR_W-1:0] sum_reg;
  logic [SW-1:0]    sum_ext, sum_lim;
  logic             accept, take;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    drain_next = drain_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_reg == CNT_W'(WINDOW - 1)) begin
            cnt_next   = '0;
            drain_next = 1'b0;
            state_next = DRAIN;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Two cycles lets the last sample clear both pipeline stages.
        drain_next = 1'b1;
        if (drain_reg) state_next = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ACCUM;
      cnt_reg   <= '0;
      drain_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      drain_reg <= drain_next;
    end
  end

  approx_abs_diff u_abs (
    .x   (exact0_reg),
    .y   (approx0_reg),
    .mag (diff)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v0_reg      <= 1'b0;
      exact0_reg  <= '0;
      approx0_reg <= '0;
      v1_reg      <= 1'b0;
      err1_reg    <= '0;
      mis1_reg    <= 1'b0;
    end else begin
      v0_reg <= accept;
      if (accept) begin
        exact0_reg  <= A + B;
        approx0_reg <= Approx;
      end
      v1_reg <= v0_reg;
      if (v0_reg) begin
        err1_reg <= diff;
        mis1_reg <= (exact0_reg != approx0_reg);
      end
    end
  end

  assign sum_ext = SW'(sum_reg) + SW'(err1_reg);
  assign sum_lim = SW'({ERR_W{1'b1}});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mism_reg <= '0;
      sum_reg  <= '0;
    end else if (take) begin
      mism_reg <= '0;
      sum_reg  <= '0;
    end else if (v1_reg) begin
      mism_reg <= mism_reg + CNT_W'(mis1_reg);
      sum_reg  <= (sum_ext > sum_lim) ? {ERR_W{1'b1}} : sum_ext[ERR_W-1:0];
    end
  end

`ifdef APPROX_ERR_MAX_EN
  logic [ADD_W-1:0] max_reg;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               max_reg <= '0;
    else if (take)                           max_reg <= '0;
    else if (v1_reg && err1_reg > max_reg)   max_reg <= err1_reg;
  end
  assign err_max = max_reg;
`else
  assign err_max = '0;
`endif

  assign mism_cnt = mism_reg;
  assign err_sum  = sum_reg;
endmodule
